seq_gen_serial: RTL and testbench

SEQ_GEN_SERIAL -- requirements
Module: seq_gen_serial

---
 rtl/seq_gen_serial.sv | 100 ++++++++++
 tb/tb_seq_gen_serial.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seq_gen_serial.sv
// Serial pattern generator: sends PATTERN MSB-first repeat_n times under out_ready flow control.
// Optional macro SEQ_GEN_GAP_EN inserts a one-cycle idle GAP between repetitions.
module seq_gen_serial #(
  parameter int                 PAT_W   = 4,
  parameter logic [PAT_W-1:0]   PATTERN = 4'b1010,
  parameter int                 CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic             out_ready,
  output logic             data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             done
);

  localparam int BC_W = $clog2(PAT_W + 1);

`ifdef SEQ_GEN_GAP_EN
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t           r_state, w_state_nxt;
  logic [PAT_W-1:0] r_sh, w_sh_nxt;
  logic [BC_W-1:0]  r_bcnt, w_bcnt_nxt;
  logic [CNT_W-1:0] r_reps, w_reps_nxt;
  logic             w_last;

  assign w_last = (r_bcnt == BC_W'(PAT_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_bcnt  <= '0;
      r_reps  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sh    <= w_sh_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_reps  <= w_reps_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_bcnt_nxt  = r_bcnt;
    w_reps_nxt  = r_reps;
    case (r_state)
      IDLE: begin
        if (start && (repeat_n != '0)) begin
          w_sh_nxt    = PATTERN;
          w_bcnt_nxt  = '0;
          w_reps_nxt  = repeat_n;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (out_ready) begin
          if (w_last) begin
            if (r_reps > CNT_W'(1)) begin
              w_reps_nxt = r_reps - CNT_W'(1);
              w_sh_nxt   = PATTERN;
              w_bcnt_nxt = '0;
`ifdef SEQ_GEN_GAP_EN
              w_state_nxt = GAP;
`else
              w_state_nxt = SHIFT;
`endif
            end else begin
              w_sh_nxt    = '0;
              w_bcnt_nxt  = '0;
              w_reps_nxt  = '0;
              w_state_nxt = DONE;
            end
          end else begin
            w_sh_nxt   = r_sh << 1;
            w_bcnt_nxt = r_bcnt + BC_W'(1);
          end
        end
      end
`ifdef SEQ_GEN_GAP_EN
      GAP:     w_state_nxt = SHIFT;
`endif
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign data_valid = (r_state == SHIFT);
  assign data_out   = data_valid & r_sh[PAT_W-1];
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);

endmodule

// File: tb/tb_seq_gen_serial.sv
// Bench for seq_gen_serial: queue-based burst model checked every cycle, plus literal trace checks.
module tb_seq_gen_serial;

  localparam int         PAT_W   = 4;
  localparam logic [3:0] PATTERN = 4'b1010;
  localparam int         CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] repeat_n = '0;
  logic             out_ready = 1'b1;
  logic             data_out, data_valid, busy, done;

  seq_gen_serial #(.PAT_W(PAT_W), .PATTERN(PATTERN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .repeat_n(repeat_n), .out_ready(out_ready),
    .data_out(data_out), .data_valid(data_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = -1;
  bit m_ok = 0;

  // Model: a burst is a queue of items; 0/1 = data bit, 2 = gap cycle, 3 = done cycle.
  int q[$];
  logic [3:0] pat = PATTERN;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      m_ok = 1;
    end else if (q.size() == 0) begin
      if (start && repeat_n != 0) begin
        for (int r = 0; r < int'(repeat_n); r++) begin
          for (int i = PAT_W - 1; i >= 0; i--) q.push_back(int'(pat[i]));
`ifdef SEQ_GEN_GAP_EN
          if (r != int'(repeat_n) - 1) q.push_back(2);
`endif
        end
        q.push_back(3);
      end
    end else begin
      if (q[0] < 2) begin
        if (out_ready) void'(q.pop_front());
      end else begin
        void'(q.pop_front());
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  bit tr_v[64], tr_d[64], tr_b[64], tr_dn[64];

  always @(negedge clk) begin
    int ev, ed, eb, edn;
    if (m_ok) begin
      ev = 0; ed = 0; eb = 0; edn = 0;
      if (q.size() != 0) begin
        eb = 1;
        if (q[0] < 2) begin ev = 1; ed = q[0]; end
        else if (q[0] == 3) edn = 1;
      end
      chk("model_data_out", int'(data_out), ed);
      chk("model_data_valid", int'(data_valid), ev);
      chk("model_busy", int'(busy), eb);
      chk("model_done", int'(done), edn);
    end
    if (t0 >= 0 && cyc - t0 >= 0 && cyc - t0 < 64) begin
      tr_v[cyc-t0]  = data_valid;
      tr_d[cyc-t0]  = data_out;
      tr_b[cyc-t0]  = busy;
      tr_dn[cyc-t0] = done;
    end
  end

  task automatic step(input logic s, input int rn, input logic ordy, input logic r);
    @(posedge clk);
    #1;
    start = s;
    repeat_n = CNT_W'(rn);
    out_ready = ordy;
    rst = r;
  endtask

  task automatic begin_trace();
    for (int i = 0; i < 64; i++) begin
      tr_v[i] = 0; tr_d[i] = 0; tr_b[i] = 0; tr_dn[i] = 0;
    end
    t0 = cyc;
  endtask

  task automatic tchk(input string name, input int r, input bit v, input bit d, input bit b, input bit dn);
    chk({name, "_valid"}, int'(tr_v[r]), int'(v));
    chk({name, "_data"},  int'(tr_d[r]), int'(d));
    chk({name, "_busy"},  int'(tr_b[r]), int'(b));
    chk({name, "_done"},  int'(tr_dn[r]), int'(dn));
  endtask

  initial begin
    int k;
    bit ev;
    repeat (3) step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(data_valid), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_data", int'(data_out), 0);

    // single repetition
    step(1, 1, 1, 0); begin_trace();
    repeat (8) step(0, 0, 1, 0);
    for (int r = 0; r < 8; r++)
      tchk("rep1", r, r >= 1 && r <= 4, r == 1 || r == 3, r >= 1 && r <= 5, r == 5);

    // three repetitions
    step(1, 3, 1, 0); begin_trace();
    repeat (17) step(0, 0, 1, 0);
    for (int r = 0; r < 17; r++) begin
`ifdef SEQ_GEN_GAP_EN
      ev = (r >= 1 && r <= 14 && r != 5 && r != 10);
      k = (r <= 4) ? r : (r <= 9) ? r - 5 : r - 10;
      tchk("rep3", r, ev, ev && (k % 2 == 1), r >= 1 && r <= 15, r == 15);
`else
      ev = (r >= 1 && r <= 12);
      tchk("rep3", r, ev, ev && (r % 2 == 1), r >= 1 && r <= 13, r == 13);
`endif
    end

    // stall on out_ready at relative cycles 2-4
    step(1, 1, 1, 0); begin_trace();
    step(0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0);
    repeat (6) step(0, 0, 1, 0);
    for (int r = 0; r < 11; r++)
      tchk("stall", r, r >= 1 && r <= 7, r == 1 || r == 6, r >= 1 && r <= 8, r == 8);

    // repeat_n=0 ignored, then start during busy ignored
    step(1, 0, 1, 0); begin_trace();
    repeat (3) step(0, 0, 1, 0);
    step(1, 1, 1, 0);
    step(0, 0, 1, 0);
    step(1, 3, 1, 0);
    repeat (6) step(0, 0, 1, 0);
    for (int r = 0; r < 13; r++)
      tchk("ignore", r, r >= 5 && r <= 8, r == 5 || r == 7, r >= 5 && r <= 9, r == 9);

    // reset mid-burst, then restart
    step(1, 2, 1, 0); begin_trace();
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(1, 1, 1, 0);
    repeat (7) step(0, 0, 1, 0);
    for (int r = 0; r < 12; r++)
      tchk("abort", r, (r >= 1 && r <= 2) || (r >= 5 && r <= 8),
           r == 1 || r == 5 || r == 7, (r >= 1 && r <= 2) || (r >= 5 && r <= 9), r == 9);

    step(0, 0, 1, 0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
